// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS CPU: fetch FSM states, reset
// vector, NOP encoding and the control FSM's CPU state codes.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE   = 2'd0,
    FETCH_REQ    = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  typedef enum logic [2:0] {
    CPU_FETCH  = 3'd0,
    CPU_DECODE = 3'd1,
    CPU_EXEC1  = 3'd2,
    CPU_EXEC2  = 3'd3,
    CPU_MEM    = 3'd4,
    CPU_WB     = 3'd5,
    CPU_HALT   = 3'd6
  } cpu_state_e;

endpackage

// File: rtl/endian_swap.sv
// Combinational 32-bit byte reversal; SWAP=0 passes data straight through.
// Shared by the instruction-fetch and data-memory paths.
module endian_swap #(
  parameter bit SWAP = 1'b1
) (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = SWAP ? {din[7:0], din[15:8], din[23:16], din[31:24]} : din;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch bus master: issues one word read per accepted fetch_req,
// holds it through waitrequest, latches the byte-swapped word, flags halt/misalignment.
module instr_fetch
  import mips_pkg::*;
#(
  parameter bit          SWAP_BYTES = 1'b1,
  parameter logic [31:0] HALT_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] RegPC,
  output logic [31:0] address,
  output logic        read,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] Instruction,
  output logic        instr_valid,
  output logic        busy,
  output logic        active,
  output logic        fault
);

  fetch_state_e state_q;
  logic [31:0]  addr_q;
  logic         read_q;
  logic [3:0]   be_q;
  logic [31:0]  instr_q;
  logic         valid_q;
  logic         busy_q;
  logic         active_q;
  logic         fault_q;
  logic [31:0]  swapped;

  endian_swap #(.SWAP(SWAP_BYTES)) u_swap (
    .din  (readdata),
    .dout (swapped)
  );

  // All outputs are registered so the bus strobe drops asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH_IDLE;
      addr_q   <= RESET_VECTOR;
      read_q   <= 1'b0;
      be_q     <= 4'b0000;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      active_q <= 1'b1;
      fault_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        FETCH_IDLE: begin
          if (fetch_req) begin
            if (RegPC == HALT_ADDR) begin
              state_q  <= FETCH_HALTED;
              active_q <= 1'b0;
            end else if (RegPC[1:0] != 2'b00) begin
              fault_q <= 1'b1;
            end else begin
              addr_q  <= RegPC;
              read_q  <= 1'b1;
              be_q    <= 4'b1111;
              busy_q  <= 1'b1;
              state_q <= FETCH_REQ;
            end
          end
        end
        FETCH_REQ: begin
          if (!waitrequest) begin
            instr_q <= swapped;
            valid_q <= 1'b1;
            read_q  <= 1'b0;
            be_q    <= 4'b0000;
            busy_q  <= 1'b0;
            state_q <= FETCH_IDLE;
          end
        end
        FETCH_HALTED: begin
          state_q <= FETCH_HALTED;
        end
        default: begin
          state_q <= FETCH_IDLE;
          read_q  <= 1'b0;
          be_q    <= 4'b0000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign address     = addr_q;
  assign read        = read_q;
  assign byteenable  = be_q;
  assign Instruction = instr_q;
  assign instr_valid = valid_q;
  assign busy        = busy_q;
  assign active      = active_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench: table of fetch vectors plus hand sequences for back-to-back,
// halt and asynchronous reset mid-request; a pass-through instance shares the stimulus.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [31:0] RegPC;
  logic        waitrequest;
  logic [31:0] readdata;

  logic [31:0] address, Instruction;
  logic        read, instr_valid, busy, active, fault;
  logic [3:0]  byteenable;

  logic [31:0] address_n, Instruction_n;
  logic        read_n, instr_valid_n, busy_n, active_n, fault_n;
  logic [3:0]  byteenable_n;

  int checks   = 0;
  int failures = 0;

  instr_fetch #(.SWAP_BYTES(1'b1)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .RegPC(RegPC),
    .address(address), .read(read), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata),
    .Instruction(Instruction), .instr_valid(instr_valid),
    .busy(busy), .active(active), .fault(fault)
  );

  instr_fetch #(.SWAP_BYTES(1'b0)) dut_ns (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .RegPC(RegPC),
    .address(address_n), .read(read_n), .byteenable(byteenable_n),
    .waitrequest(waitrequest), .readdata(readdata),
    .Instruction(Instruction_n), .instr_valid(instr_valid_n),
    .busy(busy_n), .active(active_n), .fault(fault_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc;
    int          waits;
    logic [31:0] rd;
    logic [31:0] exp_swap;
    logic [31:0] exp_pass;
    logic        exp_req;
    logic        exp_fault;
    logic        exp_active;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    RegPC       = v.pc;
    readdata    = v.rd;
    waitrequest = (v.waits > 0);
    fetch_req   = 1'b1;
    tick();
    fetch_req   = 1'b0;
    if (v.exp_req) begin
      for (int i = 0; i < v.waits; i++) begin
        chk("wait_read", {31'b0, read}, 32'd1);
        chk("wait_addr", address, v.pc);
        chk("wait_busy", {31'b0, busy}, 32'd1);
        chk("wait_be", {28'b0, byteenable}, 32'hF);
        chk("wait_valid", {31'b0, instr_valid}, 32'd0);
        if (i == 1) begin
          fetch_req = 1'b1;
          RegPC     = 32'hBFC0_0100;
        end
        tick();
        fetch_req = 1'b0;
      end
      chk("req_read", {31'b0, read}, 32'd1);
      chk("req_addr", address, v.pc);
      waitrequest = 1'b0;
      tick();
      chk("done_valid", {31'b0, instr_valid}, 32'd1);
      chk("done_read", {31'b0, read}, 32'd0);
      chk("done_be", {28'b0, byteenable}, 32'h0);
      chk("done_instr", Instruction, v.exp_swap);
      chk("done_instr_pass", Instruction_n, v.exp_pass);
      tick();
      chk("valid_one_cycle", {31'b0, instr_valid}, 32'd0);
      chk("no_queued_read", {31'b0, read}, 32'd0);
    end else begin
      chk("noreq_read", {31'b0, read}, 32'd0);
      chk("noreq_instr", Instruction, v.exp_swap);
      tick();
      chk("noreq_read2", {31'b0, read}, 32'd0);
      chk("noreq_valid", {31'b0, instr_valid}, 32'd0);
    end
    chk("fault", {31'b0, fault}, {31'b0, v.exp_fault});
    chk("active", {31'b0, active}, {31'b0, v.exp_active});
  endtask

  initial begin
    vecs[0] = '{32'hBFC0_0004, 0, 32'h0500_6510, 32'h1065_0005, 32'h0500_6510, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'hBFC0_0004, 3, 32'h0C00_000A, 32'h0A00_000C, 32'h0C00_000A, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'hBFC0_0006, 0, 32'hFFFF_FFFF, 32'h0A00_000C, 32'h0C00_000A, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{32'hBFC0_0008, 1, 32'h1234_5678, 32'h7856_3412, 32'h1234_5678, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{32'h0000_0000, 0, 32'hFFFF_FFFF, 32'hDDCC_BBAA, 32'hAABB_CCDD, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{32'hBFC0_0000, 0, 32'h1111_2222, 32'hDDCC_BBAA, 32'hAABB_CCDD, 1'b0, 1'b1, 1'b0};

    reset       = 1'b1;
    fetch_req   = 1'b0;
    RegPC       = 32'h0;
    waitrequest = 1'b1;
    readdata    = 32'h0;
    tick();
    tick();
    chk("rst_addr", address, 32'hBFC0_0000);
    chk("rst_read", {31'b0, read}, 32'd0);
    chk("rst_be", {28'b0, byteenable}, 32'h0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_active", {31'b0, active}, 32'd1);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) apply(vecs[i]);

    // Back-to-back: fetch_req held high across the completing edge.
    RegPC       = 32'hBFC0_0010;
    readdata    = 32'hAABB_CCDD;
    waitrequest = 1'b0;
    fetch_req   = 1'b1;
    tick();
    chk("b2b_read1", {31'b0, read}, 32'd1);
    tick();
    chk("b2b_done1_read", {31'b0, read}, 32'd0);
    chk("b2b_done1_valid", {31'b0, instr_valid}, 32'd1);
    tick();
    chk("b2b_read2", {31'b0, read}, 32'd1);
    chk("b2b_valid_low", {31'b0, instr_valid}, 32'd0);
    fetch_req = 1'b0;
    tick();
    chk("b2b_done2_valid", {31'b0, instr_valid}, 32'd1);
    chk("b2b_instr", Instruction, 32'hDDCC_BBAA);
    tick();

    for (int i = 4; i < 6; i++) apply(vecs[i]);

    // Reset clears halt, then reset asserted mid-request drops read at once.
    reset = 1'b1;
    #1;
    chk("rst2_active", {31'b0, active}, 32'd1);
    chk("rst2_fault", {31'b0, fault}, 32'd0);
    reset = 1'b0;
    RegPC       = 32'hBFC0_0020;
    readdata    = 32'h5555_6666;
    waitrequest = 1'b1;
    fetch_req   = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("mid_read", {31'b0, read}, 32'd1);
    chk("mid_addr", address, 32'hBFC0_0020);
    #2;
    reset = 1'b1;
    #1;
    chk("async_read", {31'b0, read}, 32'd0);
    chk("async_be", {28'b0, byteenable}, 32'h0);
    chk("async_addr", address, 32'hBFC0_0000);
    chk("async_instr", Instruction, 32'h0);
    waitrequest = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("after_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("after_rst_instr", Instruction, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
